// File: rtl/stream_pkg.sv
// Helpers shared by stream blocks: pointer/count widths and parameter legality.
package stream_pkg;

  // Bits needed to index `depth` entries (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Bits needed to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic bit latency_ok(input int latency);
    return latency >= 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth >= 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; depth need not be a power of two.
// A write on a full FIFO is taken only when a read frees a slot in the same cycle.
module sync_fifo_fwft
  import stream_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_rd) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sreg_stream_adapter.sv
// Adapts a free-running fixed-latency shift-register pipeline to a valid/ready stream,
// tagging each word with a valid bit and backpressuring upstream with a credit count.
module sreg_stream_adapter
  import stream_pkg::*;
#(
  parameter int LATENCY    = 18,
  parameter int WIDTH      = 2,
  parameter int FIFO_DEPTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] pipe_si,
  input  logic [WIDTH-1:0] pipe_so,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  localparam int CW = cnt_width(FIFO_DEPTH);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("sreg_stream_adapter: LATENCY must be >= 1");
  end
  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("sreg_stream_adapter: FIFO_DEPTH must be >= 1");
  end

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept, pop;
  logic               fifo_empty, fifo_full;
  logic [CW-1:0]      fifo_count;

  assign accept  = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign pipe_si = s_data;
  // Credits cover words in flight as well as buffered ones, so the FIFO can never overflow.
  assign s_ready = (cnt_q < CW'(FIFO_DEPTH));
  assign m_valid = !fifo_empty;

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = accept;
    for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_q[LATENCY-1]),
    .wr_data (pipe_so),
    .rd_en   (pop),
    .rd_data (m_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  a_no_write_full: assert property (@(posedge clk) disable iff (rst)
    !(vld_q[LATENCY-1] && fifo_full));
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CW'(FIFO_DEPTH));
  a_credit_covers_fifo: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= cnt_q);

endmodule

// File: tb/tb_sreg_stream_adapter.sv
// Bench for sreg_stream_adapter: three configurations share one stimulus stream and are
// checked every cycle against a queue model of outstanding words and their arrival cycles.
module tb_sreg_stream_adapter;

  localparam int NI = 3;
  localparam int MQ = 64;
  localparam int LAT [NI] = '{4, 1, 4};
  localparam int DEP [NI] = '{6, 2, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       m_ready;

  logic       s_ready_w [NI];
  logic       m_valid_w [NI];
  logic [7:0] m_data_w  [NI];
  logic [7:0] pipe_si_w [NI];
  logic [7:0] pipe_so_w [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sreg_stream_adapter #(.LATENCY(4), .WIDTH(8), .FIFO_DEPTH(6)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_w[0]), .s_data(s_data),
    .pipe_si(pipe_si_w[0]), .pipe_so(pipe_so_w[0]),
    .m_valid(m_valid_w[0]), .m_ready(m_ready), .m_data(m_data_w[0]));

  sreg_stream_adapter #(.LATENCY(1), .WIDTH(8), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_w[1]), .s_data(s_data),
    .pipe_si(pipe_si_w[1]), .pipe_so(pipe_so_w[1]),
    .m_valid(m_valid_w[1]), .m_ready(m_ready), .m_data(m_data_w[1]));

  sreg_stream_adapter #(.LATENCY(4), .WIDTH(8), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_w[2]), .s_data(s_data),
    .pipe_si(pipe_si_w[2]), .pipe_so(pipe_so_w[2]),
    .m_valid(m_valid_w[2]), .m_ready(m_ready), .m_data(m_data_w[2]));

  // External free-running pipelines (never reset).
  logic [7:0] p0 [4];
  logic [7:0] p1;
  logic [7:0] p2 [4];
  always @(posedge clk) begin
    p0[0] <= pipe_si_w[0];
    p2[0] <= pipe_si_w[2];
    for (int i = 1; i < 4; i++) begin
      p0[i] <= p0[i-1];
      p2[i] <= p2[i-1];
    end
    p1 <= pipe_si_w[1];
  end
  assign pipe_so_w[0] = p0[3];
  assign pipe_so_w[1] = p1;
  assign pipe_so_w[2] = p2[3];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: per instance, a queue of accepted-but-unpopped words with the cycle each becomes visible.
  logic [7:0] md [NI][MQ];
  int         mt [NI][MQ];
  int         mh [NI];
  int         mn [NI];
  int         first_acc [NI];
  int         first_vld [NI];
  bit         model_on = 1'b0;
  bit         ev, er, acc_m, pop_m;

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      ev = (mn[k] > 0) && (mt[k][mh[k]] <= cyc);
      er = (mn[k] < DEP[k]);
      if (model_on) begin
        check($sformatf("m_valid[%0d]", k), 32'(m_valid_w[k]), 32'(ev));
        check($sformatf("s_ready[%0d]", k), 32'(s_ready_w[k]), 32'(er));
        if (ev) check($sformatf("m_data[%0d]", k), 32'(m_data_w[k]), 32'(md[k][mh[k]]));
      end
      if (rst) begin
        mh[k] = 0;
        mn[k] = 0;
        first_acc[k] = -1;
        first_vld[k] = -1;
      end else if (model_on) begin
        acc_m = s_valid && er;
        pop_m = ev && m_ready;
        if (ev && first_vld[k] < 0) first_vld[k] = cyc;
        if (acc_m && first_acc[k] < 0) first_acc[k] = cyc;
        if (pop_m) begin
          mh[k] = (mh[k] + 1) % MQ;
          mn[k] = mn[k] - 1;
        end
        if (acc_m) begin
          md[k][(mh[k] + mn[k]) % MQ] = s_data;
          mt[k][(mh[k] + mn[k]) % MQ] = cyc + LAT[k] + 1;
          mn[k] = mn[k] + 1;
        end
      end
    end
    if (rst) model_on = 1'b1;
  end

  task automatic drain(input int n);
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (n) step();
  endtask

  logic [7:0] got [32];
  int ngot, c_first, c_last, stall0, acc, nvld;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check("reset_s_ready", 32'(s_ready_w[0]), 32'd1);
    check("reset_m_valid", 32'(m_valid_w[0]), 32'd0);
    check("reset_cnt", 32'(dut0.cnt_q), 32'd0);

    // Streaming 0..19 with the consumer always ready.
    m_ready = 1'b1; ngot = 0; stall0 = 0; c_first = 0; c_last = 0;
    for (int j = 0; j < 40; j++) begin
      s_valid = (j < 20);
      s_data  = 8'(j);
      if (s_valid && !s_ready_w[0]) stall0++;
      if (m_valid_w[0]) begin
        if (ngot < 32) got[ngot] = m_data_w[0];
        if (ngot == 0) c_first = cyc;
        c_last = cyc;
        ngot++;
      end
      step();
    end
    check("stream_no_stall", 32'(stall0), 32'd0);
    check("stream_count", 32'(ngot), 32'd20);
    check("stream_back_to_back", 32'(c_last - c_first), 32'd19);
    for (int i = 0; i < 20; i++) check($sformatf("stream_word%0d", i), 32'(got[i]), 32'(i));
    check("latency_l4", 32'(first_vld[0] - first_acc[0]), 32'd5);
    check("latency_l1", 32'(first_vld[1] - first_acc[1]), 32'd2);
    check("latency_l4_d2", 32'(first_vld[2] - first_acc[2]), 32'd5);
    drain(20);

    // Backpressure: consumer stalled, producer always valid.
    m_ready = 1'b0; s_valid = 1'b1; acc = 0;
    for (int j = 0; j < 12; j++) begin
      s_data = 8'(100 + j);
      if (s_ready_w[0]) acc++;
      step();
    end
    check("bp_accepted", 32'(acc), 32'd6);
    check("bp_s_ready_low", 32'(s_ready_w[0]), 32'd0);
    check("bp_cnt_full", 32'(dut0.cnt_q), 32'd6);
    check("bp_head_valid", 32'(m_valid_w[0]), 32'd1);
    check("bp_head_data", 32'(m_data_w[0]), 32'd100);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("bp_credit_back", 32'(s_ready_w[0]), 32'd1);
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      s_data = 8'(150 + j);
      if (s_ready_w[0]) acc++;
      step();
    end
    check("bp_one_more", 32'(acc), 32'd1);
    drain(20);

    // Random stalls on both sides.
    for (int j = 0; j < 2000; j++) begin
      s_valid = 1'($urandom % 2);
      m_ready = 1'($urandom % 2);
      s_data  = 8'($urandom);
      step();
    end
    drain(30);

    // Reset with 2 words buffered and 3 in the pipeline.
    m_ready = 1'b0; s_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      s_data = 8'(200 + j);
      step();
    end
    s_valid = 1'b0;
    step();
    check("mid_fifo_count", 32'(dut0.fifo_count), 32'd2);
    check("mid_m_valid", 32'(m_valid_w[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_m_valid", 32'(m_valid_w[0]), 32'd0);
    check("post_rst_s_ready", 32'(s_ready_w[0]), 32'd1);
    check("post_rst_cnt", 32'(dut0.cnt_q), 32'd0);
    m_ready = 1'b1; nvld = 0;
    for (int j = 0; j < 10; j++) begin
      if (m_valid_w[0]) nvld++;
      step();
    end
    check("post_rst_no_valid", 32'(nvld), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
